// File: rtl/wb_spi_flash_rd_if.sv
// ----------------------------------------------------------------------------
// wb_spi_flash_rd_if
//   Wishbone classic bus bundle between the SoC interconnect and the SPI-flash
//   read port.
//   Signals (names as seen from the slave):
//     wb_adr_i  [31:0]  byte address
//     wb_dat_i  [31:0]  write data
//     wb_sel_i  [3:0]   byte select
//     wb_we_i           write enable
//     wb_cyc_i          bus cycle
//     wb_stb_i          strobe
//     wb_dat_o  [31:0]  read data
//     wb_ack_o          read termination
//     wb_err_o          error termination
//   Modports: master (interconnect side), slave (flash reader side).
// ----------------------------------------------------------------------------
interface wb_spi_flash_rd_if;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
        input  wb_dat_o, wb_ack_o, wb_err_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
        output wb_dat_o, wb_ack_o, wb_err_o
    );
endinterface

// File: rtl/wb_spi_flash_rd.sv
// ----------------------------------------------------------------------------
// wb_spi_flash_rd
//   Wishbone classic slave that answers each bus read by fetching one 32-bit
//   word from an external SPI NOR flash (READ 0x03 + 24-bit address, SPI
//   mode 0). Writes are refused with a one-cycle error termination.
//   Ports:
//     clk         system clock
//     reset_n     asynchronous active-low reset
//     wb          Wishbone slave modport (adr/dat/sel/we/cyc/stb in,
//                 dat/ack/err out)
//     spi_sck_o   SPI clock, idles low
//     spi_cs_n_o  flash chip select, active low
//     spi_mosi_o  serial data to the flash
//     spi_miso_i  serial data from the flash
//   Parameter CLK_DIV: clk cycles per SCK half-period (>= 1).
// ----------------------------------------------------------------------------
module wb_spi_flash_rd #(
    parameter int CLK_DIV = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    wb_spi_flash_rd_if.slave        wb,
    output logic                    spi_sck_o,
    output logic                    spi_cs_n_o,
    output logic                    spi_mosi_o,
    input  logic                    spi_miso_i
);

    localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [7:0]       CMD_READ = 8'h03;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DATA,
        S_ACK,
        S_ERR
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [DIV_W-1:0] r_div, w_div_nxt;
    logic             r_phase, w_phase_nxt;   // 0: SCK low half, 1: SCK high half
    logic [4:0]       r_bit, w_bit_nxt;
    logic [31:0]      r_tx;
    logic [31:0]      r_rx;
    logic [31:0]      r_dat;
    logic             r_sck, r_cs_n, r_mosi, r_ack, r_err;

    logic             w_req;
    logic             w_half_end;
    logic             w_bit_end;
    logic [4:0]       w_last_bit;
    logic             w_shifting_nxt;
    logic             w_load;
    logic             w_enter_ack;
    logic             w_sample;
    logic             w_mosi_nxt;
    logic [31:0]      w_tx_load;
    logic             w_unused;

    // First byte off the wire lands in the least significant byte lane.
    function automatic logic [31:0] f_bytes_le(input logic [31:0] rx);
        return {rx[7:0], rx[15:8], rx[23:16], rx[31:24]};
    endfunction

    assign w_req      = wb.wb_cyc_i & wb.wb_stb_i;
    assign w_half_end = (r_div == DIV_LAST);
    assign w_bit_end  = w_half_end & r_phase;
    assign w_tx_load  = {CMD_READ, wb.wb_adr_i[23:2], 2'b00};
    assign w_unused   = ^{wb.wb_dat_i, wb.wb_sel_i, wb.wb_adr_i[31:24], wb.wb_adr_i[1:0]};

    always_comb begin
        w_last_bit = 5'd31;
        case (r_state)
            S_CMD:   w_last_bit = 5'd7;
            S_ADDR:  w_last_bit = 5'd23;
            default: w_last_bit = 5'd31;
        endcase
    end

    // Next-state logic; counters fall back to zero unless a shift phase is
    // actively running, so every phase starts from a clean count.
    always_comb begin
        w_state_nxt = r_state;
        w_div_nxt   = '0;
        w_phase_nxt = 1'b0;
        w_bit_nxt   = '0;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_state_nxt = wb.wb_we_i ? S_ERR : S_CMD;
                end
            end
            S_CMD, S_ADDR, S_DATA: begin
                if (!w_req) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_div_nxt   = w_half_end ? '0 : r_div + 1'b1;
                    w_phase_nxt = r_phase ^ w_half_end;
                    w_bit_nxt   = r_bit;
                    if (w_bit_end) begin
                        if (r_bit == w_last_bit) begin
                            w_bit_nxt = '0;
                            case (r_state)
                                S_CMD:   w_state_nxt = S_ADDR;
                                S_ADDR:  w_state_nxt = S_DATA;
                                default: w_state_nxt = S_ACK;
                            endcase
                        end else begin
                            w_bit_nxt = r_bit + 1'b1;
                        end
                    end
                end
            end
            S_ACK, S_ERR: w_state_nxt = S_IDLE;
            default:      w_state_nxt = S_IDLE;
        endcase
    end

    assign w_shifting_nxt = (w_state_nxt == S_CMD) || (w_state_nxt == S_ADDR) ||
                            (w_state_nxt == S_DATA);
    assign w_load         = (r_state == S_IDLE) && (w_state_nxt == S_CMD);
    assign w_enter_ack    = (r_state == S_DATA) && (w_state_nxt == S_ACK);
    // MISO is taken on the edge that raises SCK (end of the low half).
    assign w_sample       = (r_state == S_DATA) && w_req && w_half_end && !r_phase;

    // MOSI only moves at the start of a low half: on load, or when a bit ends.
    always_comb begin
        w_mosi_nxt = 1'b0;
        if (w_load) begin
            w_mosi_nxt = w_tx_load[31];
        end else if ((w_state_nxt == S_CMD) || (w_state_nxt == S_ADDR)) begin
            w_mosi_nxt = w_bit_end ? r_tx[30] : r_mosi;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_div   <= '0;
            r_phase <= 1'b0;
            r_bit   <= '0;
            r_sck   <= 1'b0;
            r_cs_n  <= 1'b1;
            r_mosi  <= 1'b0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_dat   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_div   <= w_div_nxt;
            r_phase <= w_phase_nxt;
            r_bit   <= w_bit_nxt;
            r_sck   <= w_shifting_nxt & w_phase_nxt;
            r_cs_n  <= !w_shifting_nxt;
            r_mosi  <= w_mosi_nxt;
            r_ack   <= w_enter_ack;
            r_err   <= (r_state == S_IDLE) && (w_state_nxt == S_ERR);
            if (w_enter_ack) begin
                r_dat <= f_bytes_le(r_rx);
            end
        end
    end

    // Shift registers carry pure data and need no reset.
    always_ff @(posedge clk) begin
        if (w_load) begin
            r_tx <= w_tx_load;
        end else if (((r_state == S_CMD) || (r_state == S_ADDR)) && w_req && w_bit_end) begin
            r_tx <= {r_tx[30:0], 1'b0};
        end
        if (w_sample) begin
            r_rx <= {r_rx[30:0], spi_miso_i};
        end
    end

    assign wb.wb_dat_o = r_dat;
    assign wb.wb_ack_o = r_ack;
    assign wb.wb_err_o = r_err;
    assign spi_sck_o   = r_sck;
    assign spi_cs_n_o  = r_cs_n;
    assign spi_mosi_o  = r_mosi;

endmodule

// File: tb/tb_wb_spi_flash_rd.sv
// ----------------------------------------------------------------------------
// tb_wb_spi_flash_rd
//   Directed bench for wb_spi_flash_rd. Two instances: CLK_DIV=2 (main
//   sequence) and CLK_DIV=1 (back-to-back reads). Each has a small behavioural
//   SPI NOR model answering READ 0x03 from a shared byte array.
//   Cycle numbering: cycle 0 is the cycle in which the request is presented;
//   the ack cycle is the edge at which the master registers ack.
// ----------------------------------------------------------------------------
module tb_wb_spi_flash_rd;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    wb_spi_flash_rd_if bus0 ();
    wb_spi_flash_rd_if bus1 ();

    logic sck0, cs0_n, mosi0, miso0;
    logic sck1, cs1_n, mosi1, miso1;

    wb_spi_flash_rd #(.CLK_DIV(2)) u_dut0 (
        .clk        (clk),
        .reset_n    (reset_n),
        .wb         (bus0),
        .spi_sck_o  (sck0),
        .spi_cs_n_o (cs0_n),
        .spi_mosi_o (mosi0),
        .spi_miso_i (miso0)
    );

    wb_spi_flash_rd #(.CLK_DIV(1)) u_dut1 (
        .clk        (clk),
        .reset_n    (reset_n),
        .wb         (bus1),
        .spi_sck_o  (sck1),
        .spi_cs_n_o (cs1_n),
        .spi_mosi_o (mosi1),
        .spi_miso_i (miso1)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- flash models ----------------
    logic [7:0] mem [0:63];

    function automatic logic mem_bit(input logic [23:0] a, input int k);
        logic [7:0] b;
        int idx;
        idx = (int'(a[5:0]) + k / 8) % 64;
        b   = mem[idx];
        return b[7 - (k % 8)];
    endfunction

    logic [31:0] f0_shift;
    int          f0_bits;
    int          rises0 = 0;
    logic [31:0] f1_shift;
    int          f1_bits;

    initial miso0 = 1'b0;
    initial miso1 = 1'b0;

    always @(posedge sck0 or posedge cs0_n) begin
        if (cs0_n) begin
            f0_bits <= 0;
        end else begin
            if (f0_bits < 32) f0_shift <= {f0_shift[30:0], mosi0};
            f0_bits <= f0_bits + 1;
        end
    end
    always @(posedge sck0) if (!cs0_n) rises0 <= rises0 + 1;
    always @(negedge sck0) if (!cs0_n && f0_bits >= 32) miso0 <= mem_bit(f0_shift[23:0], f0_bits - 32);

    always @(posedge sck1 or posedge cs1_n) begin
        if (cs1_n) begin
            f1_bits <= 0;
        end else begin
            if (f1_bits < 32) f1_shift <= {f1_shift[30:0], mosi1};
            f1_bits <= f1_bits + 1;
        end
    end
    always @(negedge sck1) if (!cs1_n && f1_bits >= 32) miso1 <= mem_bit(f1_shift[23:0], f1_bits - 32);

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Called #1 after an edge; returns #1 after the edge where ack appears.
    task automatic rd0(input logic [31:0] adr, input logic [3:0] sel,
                       output int lat, output int nrise);
        int  r_start;
        bit  done;
        bus0.wb_adr_i = adr;
        bus0.wb_sel_i = sel;
        bus0.wb_we_i  = 1'b0;
        bus0.wb_cyc_i = 1'b1;
        bus0.wb_stb_i = 1'b1;
        r_start = rises0;
        lat     = -1;
        done    = 1'b0;
        for (int n = 1; n <= 1000 && !done; n++) begin
            @(posedge clk); #1;
            if (bus0.wb_ack_o) begin
                lat  = n + 1;
                done = 1'b1;
            end
        end
        bus0.wb_cyc_i = 1'b0;
        bus0.wb_stb_i = 1'b0;
        nrise = rises0 - r_start;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int  lat, nr, r_start, errs, acks, busy, err_n, ph, a1, a2, cs_hi;
        logic [31:0] d1, d2, fa1, fa2;
        bit  done;

        reset_n = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
        for (int i = 0; i < 8; i++) mem[i] = 8'(i + 1);
        mem[16] = 8'h11; mem[17] = 8'h22; mem[18] = 8'h33; mem[19] = 8'h44;
        mem[32] = 8'hA1; mem[33] = 8'hB2; mem[34] = 8'hC3; mem[35] = 8'hD4;
        bus0.wb_adr_i = '0; bus0.wb_dat_i = '0; bus0.wb_sel_i = 4'hF;
        bus0.wb_we_i = 1'b0; bus0.wb_cyc_i = 1'b0; bus0.wb_stb_i = 1'b0;
        bus1.wb_adr_i = '0; bus1.wb_dat_i = '0; bus1.wb_sel_i = 4'hF;
        bus1.wb_we_i = 1'b0; bus1.wb_cyc_i = 1'b0; bus1.wb_stb_i = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_dat", bus0.wb_dat_o, 32'h0);
        chk("reset_ctl {ack,err,sck,cs_n,mosi}",
            {27'd0, bus0.wb_ack_o, bus0.wb_err_o, sck0, cs0_n, mosi0}, 32'b00010);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Read 0x10 -> bytes 11 22 33 44
        rd0(32'h0000_0010, 4'hF, lat, nr);
        chk("rd10_latency", 32'(lat), 32'd258);
        chk("rd10_data", bus0.wb_dat_o, 32'h4433_2211);
        chk("rd10_sck_rises", 32'(nr), 32'd64);
        chk("rd10_cmd_addr", f0_shift, 32'h0300_0010);
        chk("rd10_ack_cycle {cs_n,sck,err}", {29'd0, cs0_n, sck0, bus0.wb_err_o}, 32'b100);
        @(posedge clk); #1;
        chk("rd10_ack_one_cycle", {31'd0, bus0.wb_ack_o}, 32'd0);
        chk("rd10_cs_high_after", {31'd0, cs0_n}, 32'd1);

        // Abort during ADDR bit 10 (19th SCK rise overall)
        bus0.wb_adr_i = 32'h0000_0020; bus0.wb_we_i = 1'b0;
        bus0.wb_cyc_i = 1'b1; bus0.wb_stb_i = 1'b1;
        r_start = rises0;
        done = 1'b0;
        for (int n = 0; n < 1000 && !done; n++) begin
            @(posedge clk); #1;
            if (rises0 - r_start >= 19) done = 1'b1;
        end
        chk("abort_reached_addr_bit10", {31'd0, done}, 32'd1);
        bus0.wb_cyc_i = 1'b0; bus0.wb_stb_i = 1'b0;
        @(posedge clk); #1;
        chk("abort_cs_sck {cs_n,sck}", {30'd0, cs0_n, sck0}, 32'b10);
        acks = 0;
        for (int n = 0; n < 300; n++) begin
            @(posedge clk); #1;
            if (bus0.wb_ack_o || bus0.wb_err_o) acks++;
        end
        chk("abort_no_termination", 32'(acks), 32'd0);
        chk("abort_dat_kept", bus0.wb_dat_o, 32'h4433_2211);

        // Unaligned address with a narrow byte select still returns a full word
        rd0(32'hFF00_0023, 4'b0001, lat, nr);
        chk("rd23_cmd_addr", f0_shift, 32'h0300_0020);
        chk("rd23_data", bus0.wb_dat_o, 32'hD4C3_B2A1);
        chk("rd23_latency", 32'(lat), 32'd258);
        @(posedge clk); #1;

        // Write -> single-cycle err, no SPI activity
        bus0.wb_adr_i = 32'h0000_0010; bus0.wb_dat_i = 32'hDEAD_BEEF;
        bus0.wb_we_i = 1'b1; bus0.wb_cyc_i = 1'b1; bus0.wb_stb_i = 1'b1;
        errs = 0; acks = 0; busy = 0; err_n = -1;
        for (int n = 1; n <= 8; n++) begin
            @(posedge clk); #1;
            if (bus0.wb_err_o) begin
                errs++;
                if (err_n < 0) begin
                    err_n = n;
                    bus0.wb_cyc_i = 1'b0; bus0.wb_stb_i = 1'b0; bus0.wb_we_i = 1'b0;
                end
            end
            if (bus0.wb_ack_o) acks++;
            if (!cs0_n || sck0) busy++;
        end
        chk("wr_err_count", 32'(errs), 32'd1);
        chk("wr_err_cycle", 32'(err_n), 32'd1);
        chk("wr_no_ack", 32'(acks), 32'd0);
        chk("wr_no_spi", 32'(busy), 32'd0);
        chk("wr_dat_kept", bus0.wb_dat_o, 32'hD4C3_B2A1);

        // Asynchronous reset in the middle of DATA
        bus0.wb_adr_i = 32'h0000_0010; bus0.wb_we_i = 1'b0;
        bus0.wb_cyc_i = 1'b1; bus0.wb_stb_i = 1'b1;
        r_start = rises0;
        done = 1'b0;
        for (int n = 0; n < 1000 && !done; n++) begin
            @(posedge clk); #1;
            if (rises0 - r_start >= 40) done = 1'b1;
        end
        chk("rst_reached_data", {31'd0, done}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_async_dat", bus0.wb_dat_o, 32'h0);
        chk("rst_async_ctl {ack,err,sck,cs_n,mosi}",
            {27'd0, bus0.wb_ack_o, bus0.wb_err_o, sck0, cs0_n, mosi0}, 32'b00010);
        bus0.wb_cyc_i = 1'b0; bus0.wb_stb_i = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        rd0(32'h0000_0010, 4'hF, lat, nr);
        chk("rd_after_rst_data", bus0.wb_dat_o, 32'h4433_2211);
        chk("rd_after_rst_latency", 32'(lat), 32'd258);
        chk("rd_after_rst_rises", 32'(nr), 32'd64);

        // CLK_DIV=1: back-to-back reads of 0x0 and 0x4
        @(posedge clk); #1;
        bus1.wb_adr_i = 32'h0; bus1.wb_we_i = 1'b0;
        bus1.wb_cyc_i = 1'b1; bus1.wb_stb_i = 1'b1;
        ph = 0; a1 = -1; a2 = -1; cs_hi = 0; d1 = '0; d2 = '0; fa1 = '0; fa2 = '0;
        done = 1'b0;
        for (int n = 1; n <= 600 && !done; n++) begin
            @(posedge clk); #1;
            if (ph == 0) begin
                if (bus1.wb_ack_o) begin
                    a1 = n + 1; d1 = bus1.wb_dat_o; fa1 = f1_shift;
                    if (cs1_n) cs_hi++;
                    bus1.wb_adr_i = 32'h4;
                    ph = 1;
                end
            end else if (ph == 1) begin
                if (cs1_n) cs_hi++;
                else ph = 2;
            end else if (bus1.wb_ack_o) begin
                a2 = n + 1; d2 = bus1.wb_dat_o; fa2 = f1_shift;
                bus1.wb_cyc_i = 1'b0; bus1.wb_stb_i = 1'b0;
                done = 1'b1;
            end
        end
        chk("b2b_ack1_cycle", 32'(a1), 32'd130);
        chk("b2b_ack2_cycle", 32'(a2), 32'd260);
        chk("b2b_cs_high_gap", 32'(cs_hi), 32'd2);
        chk("b2b_data1", d1, 32'h0403_0201);
        chk("b2b_data2", d2, 32'h0807_0605);
        chk("b2b_addr1", fa1, 32'h0300_0000);
        chk("b2b_addr2", fa2, 32'h0300_0004);

        @(posedge clk); #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
